// File: rtl/reg_writeback.sv
// reg_writeback: sole register-file writer, merging the execute pipeline and a buffered
// long-latency unit onto one write port, with a pending-write scoreboard for decode.
module reg_writeback #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_data,
    output logic            ex_stall,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [AW-1:0]   lu_rd,
    input  logic [XLEN-1:0] lu_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic [NREG-1:0] pend,
    output logic            we,
    output logic [AW-1:0]   waddr,
    output logic [XLEN-1:0] wdata
);
    localparam int AF = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [AW-1:0]   f_rd   [DEPTH];
    logic [XLEN-1:0] f_data [DEPTH];
    logic [AF-1:0]   wp, rp;
    logic [CW-1:0]   cnt, cnt_next;
    logic            empty, full, push, ex_win, fifo_win, win, starve;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    logic [NREG-1:0] set_m, clr_m;

    assign empty    = wp == rp;
    assign full     = (wp[AF-1] != rp[AF-1]) && (wp[AF-2:0] == rp[AF-2:0]);
    assign lu_ready = !rst && !full;
    assign push     = lu_valid && lu_ready;
    // A forced stall hands the port to the FIFO head; otherwise ex always wins.
    assign fifo_win = !empty && (ex_stall || !ex_valid);
    assign ex_win   = ex_valid && !ex_stall;
    assign win      = fifo_win || ex_win;
    assign win_rd   = fifo_win ? f_rd[rp[AF-2:0]] : ex_rd;
    assign win_data = fifo_win ? f_data[rp[AF-2:0]] : ex_data;

    always_comb begin
        cnt_next = (!empty && ex_win) ? cnt + 1'b1 : '0;
        starve   = cnt_next == CW'(STARVE_MAX);
        set_m    = (iss_valid && iss_rd != '0) ? NREG'(1) << iss_rd : '0;
        clr_m    = fifo_win ? NREG'(1) << f_rd[rp[AF-2:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_rd[wp[AF-2:0]]   <= lu_rd;
            f_data[wp[AF-2:0]] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            ex_stall <= 1'b0;
            pend     <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (fifo_win) rp <= rp + 1'b1;
            cnt      <= starve ? '0 : cnt_next;
            ex_stall <= starve;
            // A newer issue to the same register outranks the retiring write.
            pend     <= ((pend & ~clr_m) | set_m) & ~NREG'(1);
            we       <= win && win_rd != '0;
            if (win) begin
                waddr <= win_rd;
                wdata <= win_data;
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed stimulus with a write scoreboard for reg_writeback.
module tb_reg_writeback;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
    } wr_t;

    logic clk = 1'b0, rst = 1'b1;
    logic ex_valid = 1'b0, lu_valid = 1'b0, iss_valid = 1'b0;
    logic [AW-1:0] ex_rd = '0, lu_rd = '0, iss_rd = '0;
    logic [XLEN-1:0] ex_data = '0, lu_data = '0;
    logic ex_stall, lu_ready, we;
    logic [NREG-1:0] pend;
    logic [AW-1:0] waddr;
    logic [XLEN-1:0] wdata;

    wr_t q[$];
    wr_t exp_w;
    int checks = 0, errors = 0;

    reg_writeback dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_stall(ex_stall),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .pend(pend),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        q.push_back(wr_t'({a, d}));
    endtask

    always @(negedge clk) begin
        if (we) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected write: got addr %0d data %0h, expected no write", waddr, wdata);
            end else begin
                exp_w = q.pop_front();
                check("write addr/data", {27'd0, waddr, wdata}, {27'd0, exp_w});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k, cyc;
        logic acc;
        repeat (2) tick;
        rst = 1'b0;
        #1;
        check("rst we", we, 0);
        check("rst waddr", waddr, 0);
        check("rst wdata", wdata, 0);
        check("rst ex_stall", ex_stall, 0);
        check("rst pend", pend, 0);
        check("rst lu_ready", lu_ready, 1);

        // T1: ex write, one-cycle latency
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        tick;
        ex_valid = 1'b0;
        check("t1 we", we, 1);
        check("t1 waddr", waddr, 5);
        check("t1 wdata", wdata, 32'hDEADBEEF);
        tick;
        check("t1 we idle", we, 0);

        // T2: scoreboard set by issue, cleared by retiring lu write
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick;
        iss_valid = 1'b0;
        check("t2 pend set", pend, 32'h80);
        tick;
        tick;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h12;
        expect_wr(5'd7, 32'h12);
        tick;
        lu_valid = 1'b0;
        check("t2 pend held", pend, 32'h80);
        check("t2 no write yet", we, 0);
        tick;
        check("t2 we", we, 1);
        check("t2 waddr", waddr, 7);
        check("t2 pend clr", pend, 0);

        // T3: fill FIFO behind ex traffic, then drain with wrap-around
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1; ex_rd = AW'(1 + i); ex_data = 32'hE000 + 32'(i);
            expect_wr(AW'(1 + i), 32'hE000 + 32'(i));
            lu_valid = 1'b1; lu_rd = AW'(10 + i); lu_data = 32'h1000 + 32'(i);
            tick;
        end
        ex_valid = 1'b0; lu_valid = 1'b0;
        check("t3 full lu_ready", lu_ready, 0);
        check("t3 no stall", ex_stall, 0);
        for (int i = 0; i < 4; i++) expect_wr(AW'(10 + i), 32'h1000 + 32'(i));
        k = 4; cyc = 0;
        while (k < 10 && cyc < 40) begin
            lu_valid = 1'b1; lu_rd = AW'(10 + k); lu_data = 32'h1000 + 32'(k);
            acc = lu_ready;
            tick;
            cyc++;
            if (acc) begin
                expect_wr(AW'(10 + k), 32'h1000 + 32'(k));
                k++;
            end
        end
        lu_valid = 1'b0;
        check("t3 pushes accepted", 64'(k), 10);
        repeat (8) tick;
        check("t3 drained lu_ready", lu_ready, 1);
        check("t3 queue drained", 64'(q.size()), 0);

        // T4: starvation forces one stall cycle
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
        tick;
        lu_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            ex_valid = 1'b1; ex_rd = AW'(20 + i); ex_data = 32'hA000 + 32'(i);
            expect_wr(AW'(20 + i), 32'hA000 + 32'(i));
            check("t4 no stall", ex_stall, 0);
            tick;
        end
        check("t4 stall", ex_stall, 1);
        ex_rd = 5'd28; ex_data = 32'hA008;
        expect_wr(5'd9, 32'h99);
        expect_wr(5'd28, 32'hA008);
        tick;
        check("t4 stall one cycle", ex_stall, 0);
        check("t4 fifo write addr", waddr, 9);
        tick;
        ex_valid = 1'b0;
        check("t4 held ex write we", we, 1);
        check("t4 held ex write addr", waddr, 28);

        // T5: x0 destinations and same-cycle set/clear
        ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h55;
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick;
        ex_valid = 1'b0; iss_valid = 1'b0;
        check("t5 x0 ex we", we, 0);
        check("t5 pend0", pend, 0);
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h66;
        tick;
        lu_rd = 5'd4; lu_data = 32'h44;
        expect_wr(5'd4, 32'h44);
        tick;
        lu_valid = 1'b0;
        check("t5 x0 lu we", we, 0);
        tick;
        check("t5 we after x0 pop", we, 1);
        check("t5 waddr after x0 pop", waddr, 4);
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick;
        iss_valid = 1'b0;
        check("t5 pend3 set", pend, 32'h8);
        lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h33;
        expect_wr(5'd3, 32'h33);
        tick;
        lu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick;
        iss_valid = 1'b0;
        check("t5 set wins", pend, 32'h8);
        check("t5 lu3 we", we, 1);
        check("t5 lu3 waddr", waddr, 3);

        // T6: reset mid-operation discards FIFO and scoreboard
        for (int i = 0; i < 3; i++) begin
            iss_valid = (i == 0); iss_rd = 5'd7;
            ex_valid = 1'b1; ex_rd = AW'(1 + i); ex_data = 32'hC000 + 32'(i);
            expect_wr(AW'(1 + i), 32'hC000 + 32'(i));
            lu_valid = 1'b1; lu_rd = AW'(15 + i); lu_data = 32'hB000 + 32'(i);
            tick;
        end
        iss_valid = 1'b0; ex_valid = 1'b0; lu_valid = 1'b0;
        check("t6 pend before rst", pend, 32'h88);
        check("t6 lu_ready 3 entries", lu_ready, 1);
        rst = 1'b1;
        #1;
        check("t6 lu_ready in rst", lu_ready, 0);
        tick;
        check("t6 we after rst", we, 0);
        check("t6 pend after rst", pend, 0);
        check("t6 ex_stall after rst", ex_stall, 0);
        rst = 1'b0;
        #1;
        check("t6 lu_ready after rst", lu_ready, 1);
        repeat (5) tick;
        check("t6 fifo empty no write", we, 0);
        check("t6 queue empty", 64'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
